// File: rtl/fifo_mem_responder.sv
// Golden responder model of the memory core in FIFO mode: registered pop data with
// one-cycle latency, runtime-configurable depth and combinational status flags.
module fifo_mem_responder #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned CAPACITY   = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clk_en,
  input  logic                  flush,
  input  logic [15:0]           depth,
  input  logic [3:0]            almost_count,
  input  logic                  wen_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  ren_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty
);

  localparam int unsigned CNT_WIDTH  = $clog2(CAPACITY) + 1;
  localparam int unsigned PTR_WIDTH  = $clog2(CAPACITY);
  localparam int unsigned FLAG_WIDTH = CNT_WIDTH + 5;
  localparam logic [CNT_WIDTH-1:0] CAP_CNT = CNT_WIDTH'(CAPACITY);

  logic [CNT_WIDTH-1:0]  eff_depth;
  logic [CNT_WIDTH-1:0]  count;
  logic [CNT_WIDTH-1:0]  count_next;
  logic [CNT_WIDTH-1:0]  depth_load;
  logic [PTR_WIDTH-1:0]  wr_ptr;
  logic [PTR_WIDTH-1:0]  rd_ptr;
  logic [PTR_WIDTH-1:0]  wr_ptr_next;
  logic [PTR_WIDTH-1:0]  rd_ptr_next;
  logic [DATA_WIDTH-1:0] mem [CAPACITY];
  logic                  rd_acc;
  logic                  wr_acc;

  // Pointers wrap at the configured depth, not at a power of two.
  function automatic logic [PTR_WIDTH-1:0] advance(input logic [PTR_WIDTH-1:0] p,
                                                   input logic [CNT_WIDTH-1:0] d);
    if (CNT_WIDTH'(p) == d - CNT_WIDTH'(1)) return '0;
    else                                    return p + PTR_WIDTH'(1);
  endfunction

  always_comb begin
    rd_acc      = clk_en & ~flush & ren_in & (count != '0);
    wr_acc      = clk_en & ~flush & wen_in & ((count != eff_depth) | rd_acc);
    count_next  = count + CNT_WIDTH'(wr_acc) - CNT_WIDTH'(rd_acc);
    wr_ptr_next = advance(wr_ptr, eff_depth);
    rd_ptr_next = advance(rd_ptr, eff_depth);
    if (depth == '0 || 32'(depth) > CAPACITY) depth_load = CAP_CNT;
    else                                      depth_load = CNT_WIDTH'(depth);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      eff_depth <= CAP_CNT;
      count     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= rd_acc;
      if (flush) begin
        eff_depth <= depth_load;
        count     <= '0;
        wr_ptr    <= '0;
        rd_ptr    <= '0;
      end else if (clk_en) begin
        count <= count_next;
        if (wr_acc) wr_ptr <= wr_ptr_next;
        if (rd_acc) begin
          rd_ptr   <= rd_ptr_next;
          data_out <= mem[rd_ptr];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= data_in;
  end

  // count >= D - almost_count rewritten as an unsigned sum so it cannot go negative.
  always_comb begin
    empty        = (count == '0);
    full         = (count == eff_depth);
    almost_empty = FLAG_WIDTH'(count) <= FLAG_WIDTH'(almost_count);
    almost_full  = (FLAG_WIDTH'(count) + FLAG_WIDTH'(almost_count)) >= FLAG_WIDTH'(eff_depth);
  end

endmodule

// File: tb/tb_fifo_mem_responder.sv
// Bench for fifo_mem_responder: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_fifo_mem_responder;

  localparam int CAP = 64;

  logic        clk;
  logic        reset;
  logic        clk_en;
  logic        flush;
  logic [15:0] depth;
  logic [3:0]  almost_count;
  logic        wen_in;
  logic [15:0] data_in;
  logic        ren_in;
  logic [15:0] data_out;
  logic        valid_out;
  logic        full;
  logic        empty;
  logic        almost_full;
  logic        almost_empty;

  fifo_mem_responder #(.DATA_WIDTH(16), .CAPACITY(CAP)) dut (
    .clk          (clk),
    .reset        (reset),
    .clk_en       (clk_en),
    .flush        (flush),
    .depth        (depth),
    .almost_count (almost_count),
    .wen_in       (wen_in),
    .data_in      (data_in),
    .ren_in       (ren_in),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  logic [15:0] mq[$];
  int          md = CAP;
  logic [15:0] mdout = '0;
  logic        mvout = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Advance the reference by one clock edge using the inputs that were sampled on it.
  task automatic model_update();
    logic rd, wr;
    if (!reset) begin
      mq.delete();
      md = CAP;
      mdout = '0;
      mvout = 1'b0;
    end else if (flush) begin
      mq.delete();
      md = (depth == 16'd0 || int'(depth) > CAP) ? CAP : int'(depth);
      mvout = 1'b0;
    end else if (clk_en) begin
      rd = ren_in && (mq.size() != 0);
      wr = wen_in && ((mq.size() != md) || rd);
      if (rd) mdout = mq.pop_front();
      if (wr) mq.push_back(data_in);
      mvout = rd;
    end else begin
      mvout = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    chk("data_out", 32'(data_out), 32'(mdout));
    chk("valid_out", 32'(valid_out), 32'(mvout));
    chk("empty", 32'(empty), 32'(mq.size() == 0));
    chk("full", 32'(full), 32'(mq.size() == md));
    chk("almost_empty", 32'(almost_empty), 32'(mq.size() <= int'(almost_count)));
    chk("almost_full", 32'(almost_full), 32'(mq.size() >= md - int'(almost_count)));
  end

  task automatic cyc(input logic fl, input logic ce, input logic we, input logic re,
                     input logic [15:0] din);
    flush   = fl;
    clk_en  = ce;
    wen_in  = we;
    ren_in  = re;
    data_in = din;
    @(posedge clk);
    #2;
    model_update();
  endtask

  initial begin
    reset = 1'b0; clk_en = 1'b0; flush = 1'b0; depth = '0; almost_count = '0;
    wen_in = 1'b0; ren_in = 1'b0; data_in = '0;
    cyc(0, 0, 0, 0, 0);
    chk("reset_empty", 32'(empty), 32'd1);
    chk("reset_full", 32'(full), 32'd0);
    chk("reset_valid", 32'(valid_out), 32'd0);
    cyc(0, 0, 0, 0, 0);
    reset = 1'b1;

    // Fill and drain at depth 5.
    almost_count = 4'd1; depth = 16'd5;
    cyc(1, 1, 0, 0, 0);
    for (int k = 1; k <= 5; k++) begin
      cyc(0, 1, 1, 0, 16'(k));
      if (k == 3) chk("fd_af_c3", 32'(almost_full), 32'd0);
      if (k == 4) chk("fd_af_c4", 32'(almost_full), 32'd1);
      if (k == 4) chk("fd_full_c4", 32'(full), 32'd0);
      if (k == 5) chk("fd_full_c5", 32'(full), 32'd1);
    end
    for (int k = 1; k <= 5; k++) begin
      cyc(0, 1, 0, 1, 0);
      chk("fd_valid", 32'(valid_out), 32'd1);
      chk("fd_data", 32'(data_out), 32'(k));
      if (k == 3) chk("fd_ae_c2", 32'(almost_empty), 32'd0);
      if (k == 4) chk("fd_ae_c1", 32'(almost_empty), 32'd1);
      if (k == 5) chk("fd_empty", 32'(empty), 32'd1);
    end

    // Non-power-of-two wrap at depth 3.
    depth = 16'd3;
    cyc(1, 1, 0, 0, 0);
    for (int k = 0; k < 10; k++) begin
      cyc(0, 1, 1, 0, 16'(16'h10 + k));
      cyc(0, 1, 0, 1, 0);
      chk("wrap_data", 32'(data_out), 32'(16'h10 + k));
    end

    // Push while full with a simultaneous pop.
    depth = 16'd4;
    cyc(1, 1, 0, 0, 0);
    for (int k = 0; k < 4; k++) cyc(0, 1, 1, 0, 16'(16'hA + k));
    cyc(0, 1, 1, 1, 16'hE);
    chk("fullpp_data", 32'(data_out), 32'hA);
    chk("fullpp_full", 32'(full), 32'd1);
    for (int k = 0; k < 4; k++) begin
      cyc(0, 1, 0, 1, 0);
      chk("fullpp_drain", 32'(data_out), 32'(16'hB + k));
    end

    // Push and pop on empty: no bypass.
    almost_count = 4'd0;
    cyc(1, 1, 0, 0, 0);
    cyc(0, 1, 1, 1, 16'h55);
    chk("emptypp_valid", 32'(valid_out), 32'd0);
    chk("emptypp_empty", 32'(empty), 32'd0);
    chk("emptypp_ae", 32'(almost_empty), 32'd0);
    cyc(0, 1, 0, 1, 0);
    chk("emptypp_data", 32'(data_out), 32'h55);
    chk("emptypp_vld2", 32'(valid_out), 32'd1);

    // clk_en gating with two words stored at depth 2.
    depth = 16'd2; almost_count = 4'd2;
    cyc(1, 1, 0, 0, 0);
    cyc(0, 1, 1, 0, 16'h21);
    cyc(0, 1, 1, 0, 16'h22);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, 1, 1, 16'h99);
      chk("gate_valid", 32'(valid_out), 32'd0);
      chk("gate_full", 32'(full), 32'd1);
      chk("gate_ae", 32'(almost_empty), 32'd1);
    end

    // Flush while full with depth 0 restores full capacity.
    almost_count = 4'd15; depth = 16'd0;
    cyc(1, 1, 1, 1, 16'h77);
    chk("flush_empty", 32'(empty), 32'd1);
    chk("flush_valid", 32'(valid_out), 32'd0);
    for (int k = 0; k < 3; k++) cyc(0, 1, 1, 0, 16'(16'h31 + k));
    chk("flush_d64", 32'(full), 32'd0);

    // Asynchronous reset during a pop.
    cyc(0, 1, 0, 1, 0);
    chk("rst_pre_valid", 32'(valid_out), 32'd1);
    chk("rst_pre_data", 32'(data_out), 32'h31);
    #1 reset = 1'b0;
    #1;
    chk("rst_async_valid", 32'(valid_out), 32'd0);
    chk("rst_async_data", 32'(data_out), 32'd0);
    model_update();
    cyc(0, 1, 0, 0, 0);
    reset = 1'b1;

    // Randomized traffic.
    for (int n = 0; n < 4000; n++) begin
      depth = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(0, 200))
                                          : 16'($urandom_range(1, 8));
      almost_count = 4'($urandom_range(0, 15));
      cyc(($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 85),
          ($urandom_range(0, 99) < 60), ($urandom_range(0, 99) < 50),
          16'($urandom));
    end
    cyc(0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
